// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: shared FSM state type, sweep size and fail_mask bit positions for the gate checker.
package logic_gate_pkg;
   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
   localparam int NUM_VECTORS = 256;
   localparam int GATE_W = 4;
   localparam int NUM_GATES = 7;
   localparam int AND_BIT = 0;
   localparam int OR_BIT = 1;
   localparam int NOT_A_BIT = 2;
   localparam int NAND_BIT = 3;
   localparam int NOR_BIT = 4;
   localparam int XOR_BIT = 5;
   localparam int XNOR_BIT = 6;
endpackage

// File: rtl/logic_gate_ref.sv
// logic_gate_ref: combinational golden model with the same ports as the logic_gate under test.
module logic_gate_ref
   import logic_gate_pkg::*;
(
   input  logic [GATE_W-1:0] a,
   input  logic [GATE_W-1:0] b,
   output logic [GATE_W-1:0] y_and,
   output logic [GATE_W-1:0] y_or,
   output logic [GATE_W-1:0] y_not_a,
   output logic [GATE_W-1:0] y_nand,
   output logic [GATE_W-1:0] y_nor,
   output logic [GATE_W-1:0] y_xor,
   output logic [GATE_W-1:0] y_xnor
);
   assign y_and   = a & b;
   assign y_or    = a | b;
   assign y_not_a = ~a;
   assign y_nand  = ~(a & b);
   assign y_nor   = ~(a | b);
   assign y_xor   = a ^ b;
   assign y_xnor  = ~(a ^ b);
endmodule

// File: rtl/logic_gate_checker.sv
// logic_gate_checker: sweeps all operand pairs into a logic_gate, compares against logic_gate_ref
// and records error count, sticky per-gate failures and the first failing operands.
module logic_gate_checker
   import logic_gate_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int STOP_ON_FAIL = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   output logic [GATE_W-1:0]                    a,
   output logic [GATE_W-1:0]                    b,
   input  logic [GATE_W-1:0]                    y_and,
   input  logic [GATE_W-1:0]                    y_or,
   input  logic [GATE_W-1:0]                    y_not_a,
   input  logic [GATE_W-1:0]                    y_nand,
   input  logic [GATE_W-1:0]                    y_nor,
   input  logic [GATE_W-1:0]                    y_xor,
   input  logic [GATE_W-1:0]                    y_xnor,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 pass,
   output logic [$clog2(NUM_VECTORS+1)-1:0]     err_count,
   output logic [NUM_GATES-1:0]                 fail_mask,
   output logic [GATE_W-1:0]                    first_fail_a,
   output logic [GATE_W-1:0]                    first_fail_b
);
   localparam int VW = $clog2(NUM_VECTORS);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int EW = $clog2(NUM_VECTORS + 1);
   state_t state, next;
   logic [VW-1:0] vec;
   logic [SW-1:0] settle;
   logic [GATE_W-1:0] r_and, r_or, r_not_a, r_nand, r_nor, r_xor, r_xnor;
   logic [NUM_GATES-1:0] mism;
   logic fail_now, last, settle_end, start_ok;
   logic_gate_ref u_ref (
      .a(a), .b(b),
      .y_and(r_and), .y_or(r_or), .y_not_a(r_not_a), .y_nand(r_nand),
      .y_nor(r_nor), .y_xor(r_xor), .y_xnor(r_xnor)
   );
   always_comb begin
      mism = '0;
      mism[AND_BIT]   = |(y_and ^ r_and);
      mism[OR_BIT]    = |(y_or ^ r_or);
      mism[NOT_A_BIT] = |(y_not_a ^ r_not_a);
      mism[NAND_BIT]  = |(y_nand ^ r_nand);
      mism[NOR_BIT]   = |(y_nor ^ r_nor);
      mism[XOR_BIT]   = |(y_xor ^ r_xor);
      mism[XNOR_BIT]  = |(y_xnor ^ r_xnor);
   end
   assign fail_now   = |mism;
   assign last       = vec == VW'(NUM_VECTORS - 1);
   assign settle_end = settle == SW'(SETTLE_CYCLES - 1);
   assign start_ok   = start && (state == IDLE || state == DONE);
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= next;
   always_comb begin
      next = start_ok ? APPLY :
             (state == APPLY && settle_end) ? CHECK :
             (state == CHECK) ? ((last || (STOP_ON_FAIL != 0 && fail_now)) ? DONE : APPLY) :
             state;
   end
   // Operands follow the vector counter everywhere except IDLE, so DONE keeps the last vector visible.
   always_comb begin
      busy = state == APPLY || state == CHECK;
      done = state == DONE;
      a = (state == IDLE) ? '0 : vec[VW-1:GATE_W];
      b = (state == IDLE) ? '0 : vec[GATE_W-1:0];
   end
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         vec <= '0;
         settle <= '0;
         err_count <= '0;
         fail_mask <= '0;
         first_fail_a <= '0;
         first_fail_b <= '0;
         pass <= 1'b0;
      end else begin
         if (state == APPLY) settle <= settle_end ? '0 : settle + SW'(1);
         if (state == CHECK) begin
            if (fail_now) begin
               err_count <= err_count + EW'(1);
               fail_mask <= fail_mask | mism;
               if (err_count == '0) begin
                  first_fail_a <= a;
                  first_fail_b <= b;
               end
            end
            if (next == APPLY) vec <= vec + VW'(1);
            pass <= (err_count == '0) && !fail_now;
         end
      end
   end
endmodule
